mdu: RTL

Multi-cycle multiply/divide unit sitting beside the single-cycle ALU in the EX stage of the pipelined MIPS core. It executes mult, multu, div and divu over a fixed number of cycles and writes the results into its HI/LO registers. It also executes mthi and mtlo in one cycle. It exposes a busy indication that the hazard unit uses to stall any later HI/LO access or MDU start until the operation completes.

---
 rtl/mdu_if.sv | 20 ++
 rtl/mdu.sv | 116 +++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Operand, control and result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  MDUCtrl;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output SrcA, SrcB, MDUCtrl, Start,
    input  Busy, HI, LO
  );

  modport slave (
    input  SrcA, SrcB, MDUCtrl, Start,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
//
// state | meaning
// IDLE  | no operation in flight; accepts Start, mthi/mtlo write at once
// RUN   | result held in pending regs, count runs down to the HI/LO commit
//
// The result is computed combinationally when the operation is accepted and
// parked in pending_hi/pending_lo; the count only models the pipeline latency
// seen by the hazard unit. HI/LO keep their old values until the commit edge.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset_n,
  mdu_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic          busy_q;
  logic [CW-1:0] count;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pending_hi, pending_lo;

  logic          is_mult, is_div, is_signed;
  logic [63:0]   ext_a, ext_b, product;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, uquot, urem;
  logic [31:0]   quot, rem;

  assign is_mult   = (bus.MDUCtrl == 4'd1) || (bus.MDUCtrl == 4'd2);
  assign is_div    = (bus.MDUCtrl == 4'd3) || (bus.MDUCtrl == 4'd4);
  assign is_signed = (bus.MDUCtrl == 4'd1) || (bus.MDUCtrl == 4'd3);

  // Datapath: 64-bit product and sign/magnitude division of the current operands.
  always_comb begin
    ext_a   = {{32{is_signed & bus.SrcA[31]}}, bus.SrcA};
    ext_b   = {{32{is_signed & bus.SrcB[31]}}, bus.SrcB};
    product = ext_a * ext_b;

    // Magnitudes keep 0x80000000 / -1 in range: |a| = 2^31 fits unsigned.
    a_neg = is_signed & bus.SrcA[31];
    b_neg = is_signed & bus.SrcB[31];
    a_mag = a_neg ? (32'd0 - bus.SrcA) : bus.SrcA;
    b_mag = b_neg ? (32'd0 - bus.SrcB) : bus.SrcB;
    uquot = 32'd0;
    urem  = 32'd0;
    if (b_mag != 32'd0) begin
      uquot = a_mag / b_mag;
      urem  = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    rem  = a_neg ? (32'd0 - urem) : urem;
    if (bus.SrcB == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = bus.SrcA;
    end
  end

  // Control FSM: accept operations in IDLE, count down in RUN, commit on 1->0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      count      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (is_mult) begin
              pending_hi <= product[63:32];
              pending_lo <= product[31:0];
              count      <= CW'(MULT_CYCLES);
              busy_q     <= 1'b1;
              state      <= RUN;
            end else if (is_div) begin
              pending_hi <= rem;
              pending_lo <= quot;
              count      <= CW'(DIV_CYCLES);
              busy_q     <= 1'b1;
              state      <= RUN;
            end else if (bus.MDUCtrl == 4'd5) begin
              hi_q <= bus.SrcA;
            end else if (bus.MDUCtrl == 4'd6) begin
              lo_q <= bus.SrcA;
            end
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            hi_q   <= pending_hi;
            lo_q   <= pending_lo;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q | (bus.Start & (is_mult | is_div));
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
